pool_window_feeder: RTL and testbench
=====================================

# pool_window_feeder

Streams a raster-order feature map into the 2x2 average-pooling unit. It buffers one even row, assembles each non-overlapping 2x2 window (stride 2), and drives the pooling unit's `start`/`finish` handshake for that window. It then captures the pooled pixel and emits it as an output stream. It sits directly upstream of the pooling stage and also collects that stage's result for the next layer.

## Interface
Parameters:
- `IMG_W`, 28: frame width in pixels. Must be even and ≥ 2.
- `IMG_H`, 28: frame height in pixels. Must be even and ≥ 2.
- `DATA_W`, 16: pixel width, signed (shortint).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `pix_in`  in  DATA_W  input pixel, raster order, row 0 first.
- `pix_valid`  in  1  `pix_in` is valid.
- `pix_ready`  out  1  block accepts `pix_in` this cycle.
- `win00`, `win01`, `win10`, `win11`  out  DATA_W each  window (row, col). These drive pooling ports [0][0], [0][1], [1][0], [1][1]; the unused pooling ports are tied to 0 at integration.
- `pool_start`  out  1  start request to the pooling unit.
- `pool_finish`  in  1  pooling unit done. Rises while start is high and falls after start drops.
- `pool_pixel`  in  DATA_W  pooled result, valid while `pool_finish` is high.
- `out_pixel`  out  DATA_W  captured pooled pixel.
- `out_valid`  out  1  one-cycle pulse; `out_pixel` is valid.
- `frame_done`  out  1  one-cycle pulse, coincident with the last `out_valid` of a frame.

## Operation
- FSM states:
  - FILL: `pix_ready`=1. A pixel is accepted when `pix_valid` && `pix_ready`.
  - FIRE: `pool_start`=1. Moves to WAIT_FIN in the next cycle.
  - WAIT_FIN: `pool_start`=1. When `pool_finish`=1, capture `pool_pixel` into `out_pixel`, pulse `out_valid`, and move to WAIT_CLR.
  - WAIT_CLR: `pool_start`=0. When `pool_finish`=0, move to FILL.
- Counters: `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1. Both advance only on an accepted pixel; `col` wraps to 0 and increments `row`.
- Even `row`: the pixel is written to `rowbuf[col]` (IMG_W x DATA_W registers).
- Odd `row`, even `col`: the pixel is written to the `hold` register.
- Odd `row`, odd `col`:
  - Latch `win00`=rowbuf[col-1], `win01`=rowbuf[col], `win10`=hold, `win11`=pix_in.
  - Go to FIRE.
- Windows stay stable from FIRE until the next window latch.
- No arithmetic is done here. Data passes through bit-exact; signedness is preserved.
- After the window for (IMG_H-1, IMG_W-1) completes, `frame_done` pulses together with that window's `out_valid`. `row` and `col` are already 0 at that point, so the next frame follows with no gap.
- Boundary conditions:
  - `pix_valid`=0 in FILL: hold all state.
  - `pool_finish`=1 while in FILL or FIRE: ignored. It is not captured and no `out_valid` is produced.
  - `pool_finish` already 0 when entering WAIT_CLR: leave after one cycle.
  - `rst_n` low at any time, including mid-handshake: all state returns to reset immediately and the partial frame is discarded.
- Reset values: FILL, `row`=`col`=0. Outputs: `pix_ready`=1, `pool_start`=0, `out_valid`=0, `frame_done`=0. Data outputs, `rowbuf` and `hold` all 0.

## Timing
- `pix_ready` is registered from state and falls in the cycle after the window-completing pixel is accepted.
- `pool_start` rises in the cycle after the window latch.
- `out_valid` asserts in the cycle after `pool_finish` is sampled high.
- Minimum window-to-result latency is 3 cycles, plus the pooling unit's latency.
- Minimum stall per window is 4 cycles (FIRE, WAIT_FIN, WAIT_CLR, then back to FILL).
- Throughput with a 1-cycle pooling unit: IMG_W·IMG_H accepted pixels plus 4 stall cycles per window.

## Structure
- Shared package `cnn_pkg`:
  - `pixel_t` (`logic signed [15:0]`).
  - the FSM state enum `pool_feed_state_e`.
  - default `IMG_W`/`IMG_H` constants.
- Sub-module `row_line_buffer`: a parameterised IMG_W-deep register row with write-enable/address and two read ports at col-1 and col.

## Test plan
- 4x4 frame with pixels 0..15, driven by a behavioural pooling responder that raises finish 2 cycles after start and drops it 1 cycle after start falls:
  - windows must be (0,1,4,5), (2,3,6,7), (8,9,12,13), (10,11,14,15);
  - `out_pixel` must be 2, 4, 10, 12;
  - `frame_done` must pulse with the 12.
- Negative pixels {-8,-4,-2,-6} in a 2x2 frame → window passes -8, -4, -2, -6 unchanged.
- Random `pix_valid` gaps (50 %) on a 28x28 frame of random 0..99 values → exactly 196 `out_valid` pulses, each equal to the reference model's (a+b+c+d)/4.
- Responder holding `finish` high for 5 cycles after start drops → no second `out_valid`; `pix_ready` stays low until `finish`=0.
- Spurious `pool_finish` pulse during FILL → no `out_valid`, and `row`/`col` are unaffected.
- `rst_n` asserted in WAIT_FIN mid-frame → next cycle shows `pool_start`=0 and `pix_ready`=1. A fresh 4x4 frame then yields 2, 4, 10, 12.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg -- shared types and constants for the CNN feature-map datapath.
//   pixel_t            : signed 16-bit feature-map sample
//   pool_feed_state_e  : control states of pool_window_feeder
//   IMG_W_DEF/IMG_H_DEF: default frame geometry (28x28)
//   idx_w()            : index width for a counter/address over n entries
package cnn_pkg;

  localparam int PIX_W     = 16;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  typedef logic signed [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_FILL     = 2'd0,
    ST_FIRE     = 2'd1,
    ST_WAIT_FIN = 2'd2,
    ST_WAIT_CLR = 2'd3
  } pool_feed_state_e;

  // Width needed to index n entries; never below 1 so a 1- or 2-entry
  // range still gets a real bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_window_feeder_row_line_buffer.sv
// row_line_buffer -- one DEPTH-deep row of registers holding the even row.
//   clk, rst_n : clock, asynchronous active-low reset (clears every cell)
//   wr_en      : write wr_data into cell wr_addr this cycle
//   wr_addr    : write address (column)
//   wr_data    : pixel to store
//   rd_addr    : current column
//   rd_prev    : cell rd_addr-1 (cell 0 when rd_addr is 0)
//   rd_cur     : cell rd_addr
module row_line_buffer
  import cnn_pkg::*;
#(
  parameter int DEPTH  = IMG_W_DEF,
  parameter int DATA_W = PIX_W,
  parameter int ADDR_W = idx_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_prev,
  output logic signed [DATA_W-1:0] rd_cur
);

  logic signed [DATA_W-1:0] cell_rd [DEPTH];
  logic [ADDR_W-1:0]        prev_addr;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      logic signed [DATA_W-1:0] cell_q;
      logic signed [DATA_W-1:0] cell_d;

      always_comb begin
        cell_d = cell_q;
        if (wr_en && (wr_addr == ADDR_W'(gi))) begin
          cell_d = wr_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cell_q <= '0;
        end else begin
          cell_q <= cell_d;
        end
      end

      assign cell_rd[gi] = cell_q;
    end
  endgenerate

  // The window only reads at odd columns, so col-1 is always valid there;
  // the clamp just keeps the column-0 read in range.
  assign prev_addr = (rd_addr == '0) ? '0 : rd_addr - ADDR_W'(1);
  assign rd_prev   = cell_rd[prev_addr];
  assign rd_cur    = cell_rd[rd_addr];

endmodule

// File: rtl/pool_window_feeder.sv
// pool_window_feeder -- turns a raster-order pixel stream into stride-2 2x2
// windows for the average-pooling unit, runs the start/finish handshake per
// window and re-emits the pooled pixel as an output stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pix_in/pix_valid    : input pixel stream (raster order)
//   pix_ready           : pixel accepted this cycle when also pix_valid
//   win00..win11        : latched window (row, col), stable until next latch
//   pool_start          : start request to pooling unit
//   pool_finish         : pooling unit done (pool_pixel valid while high)
//   pool_pixel          : pooled result
//   out_pixel/out_valid : captured pooled pixel, one-cycle valid pulse
//   frame_done          : pulses with the last out_valid of a frame
module pool_window_feeder
  import cnn_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int DATA_W = PIX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] pix_in,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  output logic signed [DATA_W-1:0] win00,
  output logic signed [DATA_W-1:0] win01,
  output logic signed [DATA_W-1:0] win10,
  output logic signed [DATA_W-1:0] win11,
  output logic                     pool_start,
  input  logic                     pool_finish,
  input  logic signed [DATA_W-1:0] pool_pixel,
  output logic signed [DATA_W-1:0] out_pixel,
  output logic                     out_valid,
  output logic                     frame_done
);

  localparam int COL_W = idx_w(IMG_W);
  localparam int ROW_W = idx_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  pool_feed_state_e state_q, state_d;

  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic signed [DATA_W-1:0] hold_q, hold_d;
  logic signed [DATA_W-1:0] win00_q, win00_d;
  logic signed [DATA_W-1:0] win01_q, win01_d;
  logic signed [DATA_W-1:0] win10_q, win10_d;
  logic signed [DATA_W-1:0] win11_q, win11_d;
  logic signed [DATA_W-1:0] out_pixel_q, out_pixel_d;
  logic                     out_valid_q, out_valid_d;
  logic                     frame_done_q, frame_done_d;
  // Marks that the window in flight is the frame's last, so frame_done can
  // ride on its out_valid after row/col have already wrapped.
  logic                     last_win_q, last_win_d;

  logic                     accept;
  logic                     win_done;
  logic                     buf_we;
  logic signed [DATA_W-1:0] rb_prev;
  logic signed [DATA_W-1:0] rb_cur;

  assign accept   = (state_q == ST_FILL) && pix_valid;
  assign win_done = accept && row_q[0] && col_q[0];
  assign buf_we   = accept && !row_q[0];

  row_line_buffer #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W),
    .ADDR_W (COL_W)
  ) u_rowbuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_we),
    .wr_addr (col_q),
    .wr_data (pix_in),
    .rd_addr (col_q),
    .rd_prev (rb_prev),
    .rd_cur  (rb_cur)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:     if (win_done)     state_d = ST_FIRE;
      ST_FIRE:                       state_d = ST_WAIT_FIN;
      ST_WAIT_FIN: if (pool_finish)  state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!pool_finish) state_d = ST_FILL;
      default:                       state_d = ST_FILL;
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    pix_ready  = (state_q == ST_FILL);
    pool_start = (state_q == ST_FIRE) || (state_q == ST_WAIT_FIN);
  end

  // Counters, hold register, window latch and result capture
  always_comb begin
    row_d        = row_q;
    col_d        = col_q;
    hold_d       = hold_q;
    win00_d      = win00_q;
    win01_d      = win01_q;
    win10_d      = win10_q;
    win11_d      = win11_q;
    last_win_d   = last_win_q;
    out_pixel_d  = out_pixel_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;

    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end

      if (row_q[0] && !col_q[0]) begin
        hold_d = pix_in;
      end

      if (win_done) begin
        win00_d    = rb_prev;
        win01_d    = rb_cur;
        win10_d    = hold_q;
        win11_d    = pix_in;
        last_win_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
      end
    end

    // finish outside WAIT_FIN (spurious or lingering) is deliberately ignored
    if ((state_q == ST_WAIT_FIN) && pool_finish) begin
      out_valid_d  = 1'b1;
      out_pixel_d  = pool_pixel;
      frame_done_d = last_win_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      hold_q       <= '0;
      win00_q      <= '0;
      win01_q      <= '0;
      win10_q      <= '0;
      win11_q      <= '0;
      last_win_q   <= 1'b0;
      out_pixel_q  <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      hold_q       <= hold_d;
      win00_q      <= win00_d;
      win01_q      <= win01_d;
      win10_q      <= win10_d;
      win11_q      <= win11_d;
      last_win_q   <= last_win_d;
      out_pixel_q  <= out_pixel_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win00      = win00_q;
  assign win01      = win01_q;
  assign win10      = win10_q;
  assign win11      = win11_q;
  assign out_pixel  = out_pixel_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_feeder.sv
// Bench for pool_window_feeder: three instances (4x4, 2x2, 28x28) share one
// stimulus stream selected by 'sel', one pooling responder and one monitor.
// Expected windows/results come from the input frame held in the bench.
module tb_pool_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic signed [15:0] pix_in;
  logic               pix_valid;
  logic               pool_finish;
  logic signed [15:0] pool_pixel;
  int                 sel;

  logic               pv [3];
  logic               pr [3];
  logic               ps [3];
  logic               ov [3];
  logic               fd [3];
  logic signed [15:0] w00 [3];
  logic signed [15:0] w01 [3];
  logic signed [15:0] w10 [3];
  logic signed [15:0] w11 [3];
  logic signed [15:0] op [3];

  assign pv[0] = pix_valid && (sel == 0);
  assign pv[1] = pix_valid && (sel == 1);
  assign pv[2] = pix_valid && (sel == 2);

  pool_window_feeder #(.IMG_W(4), .IMG_H(4), .DATA_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pv[0]), .pix_ready(pr[0]),
    .win00(w00[0]), .win01(w01[0]), .win10(w10[0]), .win11(w11[0]),
    .pool_start(ps[0]), .pool_finish(pool_finish), .pool_pixel(pool_pixel),
    .out_pixel(op[0]), .out_valid(ov[0]), .frame_done(fd[0]));

  pool_window_feeder #(.IMG_W(2), .IMG_H(2), .DATA_W(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pv[1]), .pix_ready(pr[1]),
    .win00(w00[1]), .win01(w01[1]), .win10(w10[1]), .win11(w11[1]),
    .pool_start(ps[1]), .pool_finish(pool_finish), .pool_pixel(pool_pixel),
    .out_pixel(op[1]), .out_valid(ov[1]), .frame_done(fd[1]));

  pool_window_feeder #(.IMG_W(28), .IMG_H(28), .DATA_W(16)) u_dut28 (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pv[2]), .pix_ready(pr[2]),
    .win00(w00[2]), .win01(w01[2]), .win10(w10[2]), .win11(w11[2]),
    .pool_start(ps[2]), .pool_finish(pool_finish), .pool_pixel(pool_pixel),
    .out_pixel(op[2]), .out_valid(ov[2]), .frame_done(fd[2]));

  // Signals of the currently selected instance
  logic               m_ready, m_start, m_ov, m_fd;
  logic signed [15:0] m_w00, m_w01, m_w10, m_w11, m_op;
  assign m_ready = pr[sel];
  assign m_start = ps[sel];
  assign m_ov    = ov[sel];
  assign m_fd    = fd[sel];
  assign m_w00   = w00[sel];
  assign m_w01   = w01[sel];
  assign m_w10   = w10[sel];
  assign m_w11   = w11[sel];
  assign m_op    = op[sel];

  int compared   = 0;
  int mismatched = 0;
  int out_cnt    = 0;

  typedef struct {
    int a, b, c, d;
  } win_t;
  typedef struct {
    int pix;
    bit last;
  } res_t;

  win_t win_q[$];
  res_t out_q[$];

  int hold_cycles = 1;
  bit resp_busy   = 1'b0;
  bit chk_ready   = 1'b1;
  int spur_req    = 0;
  int spur_done   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pooling-unit model: finish 2 cycles after start, held until hold_cycles
  // after start falls. Also serves spurious finish pulses on request.
  initial begin
    pool_finish = 1'b0;
    pool_pixel  = '0;
    forever begin
      @(posedge clk); #1;
      if (m_start) begin
        resp_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        pool_pixel  = 16'((int'(m_w00) + int'(m_w01) + int'(m_w10) + int'(m_w11)) / 4);
        pool_finish = 1'b1;
        for (int k = 0; k < 50 && m_start; k++) begin
          @(posedge clk); #1;
        end
        repeat (hold_cycles) @(posedge clk);
        #1;
        pool_finish = 1'b0;
        resp_busy   = 1'b0;
      end else if (spur_req != spur_done) begin
        pool_pixel  = 16'sh7777;
        pool_finish = 1'b1;
        @(posedge clk); #1;
        pool_finish = 1'b0;
        spur_done++;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    bit prev_start;
    win_t w;
    res_t r;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_start && !prev_start) begin
          if (win_q.size() == 0) begin
            chk("unexpected_window", 1, 0);
          end else begin
            w = win_q.pop_front();
            $display("window dut%0d: %0d %0d %0d %0d", sel, m_w00, m_w01, m_w10, m_w11);
            chk("win00", m_w00, w.a);
            chk("win01", m_w01, w.b);
            chk("win10", m_w10, w.c);
            chk("win11", m_w11, w.d);
          end
        end
        if (m_ov) begin
          out_cnt++;
          $display("out dut%0d: pixel=%0d frame_done=%0b", sel, m_op, m_fd);
          if (out_q.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            r = out_q.pop_front();
            chk("out_pixel", m_op, r.pix);
            chk("frame_done", m_fd, r.last);
          end
        end else if (m_fd) begin
          chk("frame_done_without_out_valid", 1, 0);
        end
        for (int i = 0; i < 3; i++) begin
          if (i != sel && (ov[i] || fd[i])) chk("idle_instance_output", 1, 0);
        end
        if (chk_ready && resp_busy && pool_finish) chk("pix_ready_during_finish", m_ready, 0);
      end
      prev_start = m_start;
    end
  end

  // Offer one pixel, with random idle cycles, until accepted.
  task automatic send_pixel(input int v, input int gap_pct);
    bit done = 1'b0;
    int budget = 0;
    while (!done) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        pix_valid = 1'b0;
      end else begin
        pix_valid = 1'b1;
        pix_in    = 16'(v);
      end
      @(negedge clk);
      if (pix_valid && m_ready) done = 1'b1;
      @(posedge clk); #1;
      budget++;
      if (!done && budget > 300) begin
        chk("accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
    pix_valid = 1'b0;
  endtask

  // mode 0: 0..N-1, mode 1: random 0..99, mode 2: fixed negative 2x2 set.
  // spur_at >= 0 requests a spurious finish pulse after that pixel index.
  task automatic send_frame(input int w, input int h, input int mode,
                            input int gap_pct, input int spur_at);
    int f[28][28];
    int neg[4] = '{-8, -4, -2, -6};
    win_t ew;
    res_t er;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        case (mode)
          0:       f[r][c] = r * w + c;
          1:       f[r][c] = int'($urandom_range(99));
          default: f[r][c] = neg[(r * w + c) % 4];
        endcase
      end
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        send_pixel(f[r][c], gap_pct);
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          ew.a = f[r-1][c-1];
          ew.b = f[r-1][c];
          ew.c = f[r][c-1];
          ew.d = f[r][c];
          er.pix  = (ew.a + ew.b + ew.c + ew.d) / 4;
          er.last = (r == h - 1) && (c == w - 1);
          win_q.push_back(ew);
          out_q.push_back(er);
        end
        if (r * w + c == spur_at) begin
          spur_req++;
          for (int k = 0; k < 20 && spur_done != spur_req; k++) @(posedge clk);
          repeat (2) @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 400 && (out_q.size() != 0 || resp_busy); k++) @(posedge clk);
    chk(name, out_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    win_t ew;
    res_t er;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    sel       = 0;

    // Reset state of every instance
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_pix_ready", pr[i], 1);
      chk("rst_pool_start", ps[i], 0);
      chk("rst_out_valid", ov[i], 0);
      chk("rst_frame_done", fd[i], 0);
      chk("rst_out_pixel", op[i], 0);
      chk("rst_win_or", w00[i] | w01[i] | w10[i] | w11[i], 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4x4 ramp: windows (0,1,4,5)...(10,11,14,15), results 2,4,10,12
    sel = 0;
    send_frame(4, 4, 0, 0, -1);
    drain("drain_4x4_ramp");

    // 2x2 negative pixels pass through unchanged
    sel = 1;
    send_frame(2, 2, 2, 0, -1);
    drain("drain_2x2_negative");

    // 28x28 random values with 50% valid gaps: 196 results
    sel  = 2;
    base = out_cnt;
    send_frame(28, 28, 1, 50, -1);
    drain("drain_28x28_random");
    chk("out_valid_count_28x28", out_cnt - base, 196);

    // finish lingering 5 cycles after start drops
    sel         = 0;
    hold_cycles = 5;
    send_frame(4, 4, 0, 0, -1);
    drain("drain_hold5");
    hold_cycles = 1;

    // spurious finish pulse while filling
    send_frame(4, 4, 0, 0, 6);
    drain("drain_spurious");

    // reset in WAIT_FIN mid-frame
    chk_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_pixel(i, 0);
    ew.a = 0; ew.b = 1; ew.c = 4; ew.d = 5;
    er.pix = 2; er.last = 1'b0;
    win_q.push_back(ew);
    out_q.push_back(er);
    for (int k = 0; k < 10 && !m_start; k++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_pool_start", m_start, 0);
    chk("midreset_pix_ready", m_ready, 1);
    win_q.delete();
    out_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 20 && (resp_busy || pool_finish); k++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_ready = 1'b1;
    send_frame(4, 4, 0, 0, -1);
    drain("drain_after_reset");

    chk("leftover_windows", win_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
